imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction memory word-address width (2^ADDR_W words).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch is forced a grant.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, substitute read data for rejected accesses.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 boot_hold  in  1  high = program-load phase; CPU fetch blocked.
REQ-007 f_req  in  1  CPU fetch read request.
REQ-008 f_addr  in  32  fetch byte address.
REQ-009 f_gnt  out  1  fetch request accepted this cycle.
REQ-010 f_rvalid  out  1  rdata holds fetch read data.
REQ-011 l_req  in  1  loader/debug request.
REQ-012 l_we  in  1  loader write (1) or read (0).
REQ-013 l_addr  in  32  loader byte address.
REQ-014 l_wdata  in  32  loader write data.
REQ-015 l_gnt  out  1  loader request accepted this cycle.
REQ-016 l_rvalid  out  1  rdata holds loader read data.
REQ-017 rdata  out  32  shared read-data bus.
REQ-018 mem_en, mem_we  out  1 each  memory access enable and write strobe.
REQ-019 mem_addr  out  ADDR_W  memory word address; mem_wdata  out  32  write data.
REQ-020 mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-021 addr_err  out  1  one-cycle out-of-range access pulse.

Function
REQ-022 SHALL implement states BOOT and RUN; BOOT->RUN on a cycle with boot_hold=0; RUN->BOOT on a cycle with boot_hold=1.
REQ-023 In BOOT, f_gnt SHALL be 0; l_req SHALL be granted the same cycle.
REQ-024 In RUN, at most one grant per cycle; loader wins simultaneous requests unless starve_cnt==STARVE_LIMIT, then fetch wins.
REQ-025 starve_cnt SHALL increment when f_req=1 and f_gnt=0 in RUN, saturate at STARVE_LIMIT, clear on f_gnt or f_req=0.
REQ-026 Grants SHALL be combinational: mem_en=f_gnt|l_gnt; mem_addr=granted addr[ADDR_W+1:2]; mem_we=l_gnt&l_we; mem_wdata=l_wdata.
REQ-027 Each granted read SHALL pulse exactly one of f_rvalid/l_rvalid one cycle after grant, rdata=mem_rdata; writes produce no rvalid.
REQ-028 A read granted in the cycle of a RUN->BOOT transition SHALL still complete its rvalid.
REQ-029 Byte-address bits [1:0] SHALL be ignored.

Reset
REQ-030 On reset: state=BOOT, starve_cnt=0, response-owner register cleared; f_rvalid, l_rvalid, addr_err, f_gnt, l_gnt, mem_en, mem_we=0; rdata=0.
REQ-031 Reset asserted the cycle after a grant SHALL suppress that grant's rvalid.

Configuration
REQ-032 With IMEM_ARB_BOUNDS_CHECK_EN defined: access with any address bit above ADDR_W+1 set is granted, mem_en=0, writes dropped, reads return NOP_WORD with normal rvalid timing, addr_err pulses with the rvalid slot.
REQ-033 Without IMEM_ARB_BOUNDS_CHECK_EN: upper address bits ignored (aliasing), addr_err tied 0.

Structure
REQ-034 Package imem_arb_pkg SHALL hold the BOOT/RUN state encoding, NOP_WORD constant and parameter defaults.
REQ-035 Starvation counter SHALL be sub-module imem_arb_starve_ctr.

Verification
REQ-036 Reset, boot_hold=1, loader writes 32'h3e800093 to byte 0x8 -> mem_we=1, mem_addr=2; f_req=1 sees f_gnt=0.
REQ-037 boot_hold=0, f_addr=0x8 -> f_gnt same cycle, next cycle f_rvalid=1, rdata=32'h3e800093.
REQ-038 RUN, f_req and l_req both high continuously, STARVE_LIMIT=4 -> 4 loader grants, then 1 fetch grant, repeating.
REQ-039 Read grant then reset next cycle -> no rvalid; state BOOT.
REQ-040 With macro, ADDR_W=8, f_addr=0x400 -> mem_en=0, next cycle f_rvalid=1, rdata=32'h00000013, addr_err=1; without macro -> mem_addr=0.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Holds the BOOT/RUN state encoding, the response-owner encoding and the parameter defaults.
package imem_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_LOAD  = 2'd2
    } resp_owner_t;

    localparam int unsigned ADDR_W_DEF       = 8;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam logic [31:0] NOP_WORD_DEF     = 32'h0000_0013;

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Counts consecutive denied fetch cycles in RUN and flags when fetch must win the next conflict.
// LIMIT must be at least 1.
module imem_arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic f_req,
    input  logic f_gnt,
    output logic starved
);

    localparam int unsigned    CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (f_gnt || !f_req) begin
            cnt <= '0;
        end else if (run && (cnt != LIMIT_C)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign starved = (cnt == LIMIT_C);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a CPU fetch port and a loader/debug port onto one single-port instruction memory.
// Define IMEM_ARB_BOUNDS_CHECK_EN to reject out-of-range accesses (NOP read data, addr_err pulse).
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_hold,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              addr_err
);

    arb_state_t  state;
    resp_owner_t owner;
    logic        resp_oob;
    logic        starved;
    logic        oob;
    logic [31:0] sel_addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            case (state)
                ST_BOOT: if (!boot_hold) state <= ST_RUN;
                ST_RUN:  if (boot_hold)  state <= ST_BOOT;
                default: state <= ST_BOOT;
            endcase
        end
    end

    // NOTE: both grants get a default before any branch, otherwise always_comb would infer latches.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            if (state == ST_BOOT) begin
                l_gnt = l_req;
            end else if (f_req && l_req) begin
                f_gnt = starved;
                l_gnt = !starved;
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end
    end

    imem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_RUN),
        .f_req   (f_req),
        .f_gnt   (f_gnt),
        .starved (starved)
    );

    assign sel_addr  = f_gnt ? f_addr : l_addr;
    assign mem_addr  = sel_addr[ADDR_W+1:2];
    assign mem_en    = (f_gnt || l_gnt) && !oob;
    assign mem_we    = l_gnt && l_we && !oob;
    assign mem_wdata = l_wdata;

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
    logic unused_addr_bits;
    assign oob              = |sel_addr[31:ADDR_W+2];
    assign addr_err         = resp_oob && !reset;
    assign unused_addr_bits = ^sel_addr[1:0];
`else
    logic unused_addr_bits;
    assign oob              = 1'b0;
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[31:ADDR_W+2]};
`endif

    // Remembers who owns next cycle's read data; writes leave no owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= RESP_NONE;
            resp_oob <= 1'b0;
        end else begin
            if (f_gnt)             owner <= RESP_FETCH;
            else if (l_gnt && !l_we) owner <= RESP_LOAD;
            else                   owner <= RESP_NONE;
            resp_oob <= (f_gnt || l_gnt) && oob;
        end
    end

    // Gated by reset so a reset arriving right after a grant swallows its response.
    assign f_rvalid = (owner == RESP_FETCH) && !reset;
    assign l_rvalid = (owner == RESP_LOAD) && !reset;

    always_comb begin
        rdata = '0;
        if (f_rvalid || l_rvalid) rdata = resp_oob ? NOP_WORD : mem_rdata;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural single-port memory.
// Expectations follow IMEM_ARB_BOUNDS_CHECK_EN when the bench is built with it.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_hold;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [256];

`ifdef IMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .boot_hold (boot_hold),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] pat;
        pat = 10'b10_0001_0000;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1; boot_hold = 1'b1;
        f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset state, with a loader request pending that must not be granted.
        repeat (2) @(negedge clk);
        l_req = 1'b1;
        #1;
        check("rst_l_gnt",    l_gnt,    0);
        check("rst_f_gnt",    f_gnt,    0);
        check("rst_mem_en",   mem_en,   0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_f_rvalid", f_rvalid, 0);
        check("rst_l_rvalid", l_rvalid, 0);
        check("rst_rdata",    rdata,    0);
        check("rst_addr_err", addr_err, 0);
        @(negedge clk);

        // BOOT: loader write to byte 0x8, fetch blocked.
        reset = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'h3e80_0093;
        f_req = 1'b1; f_addr = 32'h8;
        #1;
        check("boot_l_gnt",    l_gnt,     1);
        check("boot_f_gnt",    f_gnt,     0);
        check("boot_mem_en",   mem_en,    1);
        check("boot_mem_we",   mem_we,    1);
        check("boot_mem_addr", mem_addr,  2);
        check("boot_wdata",    mem_wdata, 32'h3e80_0093);
        @(negedge clk);

        // Second write, byte-offset bits must be ignored; first write gives no rvalid.
        l_addr = 32'hF; l_wdata = 32'h0010_0113;
        #1;
        check("wr_no_l_rvalid", l_rvalid, 0);
        check("wr_no_f_rvalid", f_rvalid, 0);
        check("wr2_mem_addr",   mem_addr, 3);
        @(negedge clk);

        l_req = 1'b0; f_req = 1'b0; boot_hold = 1'b0;
        #1;
        check("idle_mem_en", mem_en, 0);
        @(negedge clk);

        // RUN: fetch of byte 0x8.
        f_req = 1'b1; f_addr = 32'h8;
        #1;
        check("run_f_gnt",    f_gnt,    1);
        check("run_mem_addr", mem_addr, 2);
        check("run_mem_we",   mem_we,   0);
        @(negedge clk);

        f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'hD;
        #1;
        check("fetch_rvalid", f_rvalid, 1);
        check("fetch_rdata",  rdata,    32'h3e80_0093);
        check("fetch_no_l",   l_rvalid, 0);
        check("ld_l_gnt",     l_gnt,    1);
        @(negedge clk);

        // Continuous contention: four loader grants then one fetch grant, twice.
        f_req = 1'b1; f_addr = 32'h8; l_addr = 32'hC;
        #1;
        check("ld_rvalid", l_rvalid, 1);
        check("ld_rdata",  rdata,    32'h0010_0113);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                check("arb_f_rvalid", f_rvalid, pat[i-1]);
                check("arb_l_rvalid", l_rvalid, !pat[i-1]);
                check("arb_rdata",    rdata,    pat[i-1] ? 32'h3e80_0093 : 32'h0010_0113);
            end
            check("arb_f_gnt", f_gnt, pat[i]);
            check("arb_l_gnt", l_gnt, !pat[i]);
        end
        @(negedge clk);

        // Fetch granted in the same cycle RUN drops back to BOOT.
        l_req = 1'b0; boot_hold = 1'b1;
        #1;
        check("last_f_rvalid", f_rvalid, 1);
        check("tr_f_gnt",      f_gnt,    1);
        @(negedge clk);
        #1;
        check("tr_f_rvalid",   f_rvalid, 1);
        check("tr_rdata",      rdata,    32'h3e80_0093);
        check("tr_boot_f_gnt", f_gnt,    0);
        @(negedge clk);

        f_req = 1'b0; boot_hold = 1'b0;
        #1;
        check("tr_rvalid_end", f_rvalid, 0);
        @(negedge clk);

        // Reset right after a read grant swallows its rvalid and returns to BOOT.
        f_req = 1'b1;
        #1;
        check("pre_rst_f_gnt", f_gnt, 1);
        @(negedge clk);
        reset = 1'b1; f_req = 1'b0;
        #1;
        check("rst_sup_rvalid", f_rvalid, 0);
        check("rst_sup_rdata",  rdata,    0);
        @(negedge clk);
        reset = 1'b0; f_req = 1'b1;
        #1;
        check("post_rst_boot_f_gnt", f_gnt,    0);
        check("post_rst_f_rvalid",   f_rvalid, 0);
        @(negedge clk);

        // Out-of-range fetch at byte 0x400.
        f_addr = 32'h400;
        #1;
        check("oob_f_gnt",    f_gnt,    1);
        check("oob_mem_en",   mem_en,   !BC);
        check("oob_mem_addr", mem_addr, 0);
        @(negedge clk);

        f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h40C; l_wdata = 32'hdead_beef;
        #1;
        check("oob_f_rvalid", f_rvalid, 1);
        check("oob_rdata",    rdata,    BC ? 32'h0000_0013 : 32'h0);
        check("oob_addr_err", addr_err, BC);
        check("oobw_l_gnt",   l_gnt,    1);
        check("oobw_mem_we",  mem_we,   !BC);
        @(negedge clk);

        l_req = 1'b0;
        #1;
        check("oobw_l_rvalid", l_rvalid, 0);
        check("oobw_addr_err", addr_err, BC);
        @(negedge clk);
        #1;
        check("addr_err_clear", addr_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
